// File: rtl/adder5_chain_sequencer.sv
// Drives one external 5-bit adder slice, one slice per clock, to add two
// 5*SLICES-bit operands with the carry held in a register between slices.
module adder5_chain_sequencer #(
  parameter int SLICES = 4,
  localparam int W = 5 * SLICES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic [4:0]   add_a,
  output logic [4:0]   add_b,
  output logic         add_cin,
  input  logic [4:0]   add_s,
  input  logic         add_cout
);

  localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          run;

  assign run  = (state == RUN);
  assign busy = run;
  assign done = (state == DONE);

  // Slice operands come only from registers; idle slice sees zeros.
  assign add_a   = run ? a_reg[5*idx +: 5] : 5'd0;
  assign add_b   = run ? b_reg[5*idx +: 5] : 5'd0;
  assign add_cin = run ? carry : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (1'b1)
        run: begin
          sum[5*idx +: 5] <= add_s;
          carry           <= add_cout;
          if (idx == LAST) begin
            cout  <= add_cout;
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          if (start) begin
            a_reg <= a_in;
            b_reg <= b_in;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder5_chain_sequencer.sv
// Scoreboard bench for adder5_chain_sequencer: driver queues expected
// {cout,sum}; a negedge monitor pops and compares on every done pulse.
module tb_adder5_chain_sequencer;

  localparam int SLICES = 4;
  localparam int W = 5 * SLICES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [4:0]   add_a;
  logic [4:0]   add_b;
  logic         add_cin;
  logic [4:0]   add_s;
  logic         add_cout;

  int checks = 0;
  int passes = 0;
  logic [W:0] sb[$];
  int cin_hi;

  adder5_chain_sequencer #(.SLICES(SLICES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  // External combinational 5-bit slice.
  assign {add_cout, add_s} = 6'(add_a) + 6'(add_b) + 6'(add_cin);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W:0] act,
                     input logic [W:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done=1 expected no result");
        end else begin
          chk("result", {cout, sum}, sb.pop_front());
        end
      end
      if (!busy)
        chk("idle_slice", {10'd0, add_a, add_b, add_cin}, '0);
      if (busy && add_cin) cin_hi++;
    end
  end

  function automatic logic [W:0] ref_add(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c);
    return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
  endfunction

  // Call shortly after a posedge with the DUT in IDLE/DONE.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    sb.push_back(ref_add(a, b, c));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done at negedge; returns number of busy cycles seen.
  task automatic wait_done(input string name, output int nbusy);
    bit got = 0;
    nbusy = 0;
    for (int i = 0; i < SLICES + 4 && !got; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) got = 1;
    end
    if (!got) begin
      checks++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nb;
    logic [W-1:0] ra, rb;
    logic rc;

    // 1. reset held, start toggled
    for (int i = 0; i < 4; i++) begin
      start = i[0];
      @(negedge clk);
      chk("reset_outs", {busy, done, cout, sum},
          '0);
      chk("reset_slice", {10'd0, add_a, add_b, add_cin}, '0);
    end
    start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", {busy, done, cout, sum}, '0);
    @(posedge clk);
    #1;

    // 2. simple add, latency, hold
    issue(20'h00001, 20'h00001, 1'b0);
    wait_done("simple", nb);
    chk("busy_cycles", (W+1)'(nb), (W+1)'(SLICES));
    repeat (3) @(negedge clk);
    chk("sum_held", {cout, sum}, {1'b0, 20'h00002});
    chk("idle_no_done", (W+1)'({busy, done}), '0);
    @(posedge clk);
    #1;

    // 3. carry ripple through every slice
    cin_hi = 0;
    issue(20'hFFFFF, 20'h00000, 1'b1);
    wait_done("ripple", nb);
    chk("ripple_cin_cycles", (W+1)'(cin_hi), (W+1)'(SLICES));

    // 4. max operands, then random vectors
    issue(20'hFFFFF, 20'hFFFFF, 1'b1);
    wait_done("max", nb);
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      issue(ra, rb, rc);
      wait_done("rand", nb);
    end

    // 5. start held through RUN, back-to-back in DONE
    issue(20'h12345, 20'h01111, 1'b0);
    start = 1'b1;
    a_in = 20'hABCDE;
    b_in = 20'h55555;
    cin = 1'b1;
    nb = 0;
    while (!done && nb < SLICES + 4) begin
      @(negedge clk);
      nb++;
    end
    a_in = 20'h00010;
    b_in = 20'h00005;
    cin = 1'b0;
    sb.push_back(ref_add(20'h00010, 20'h00005, 1'b0));
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_run", (W+1)'(busy), (W+1)'(1));
    wait_done("b2b", nb);
    chk("b2b_sum", {cout, sum}, {1'b0, 20'h00015});

    // 6. asynchronous reset mid-RUN at idx=2
    issue(20'h7BCDE, 20'h31234, 1'b1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_outs", {busy, done, cout, sum}, '0);
    chk("abort_slice", {10'd0, add_a, add_b, add_cin}, '0);
    void'(sb.pop_back());
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(20'd3, 20'd4, 1'b0);
    wait_done("after_abort", nb);
    chk("after_abort_sum", {cout, sum}, (W+1)'(7));

    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0",
                  sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
